// File: rtl/ifft_ola_reader.sv
// Reads finished IFFT frames point by point, overlap-adds the first half with the
// stored second half of the previous frame and streams saturated 16-bit samples out.
module ifft_ola_reader #(
    parameter int FRAME_LEN = 1024,
    parameter int ADDR_W    = 10,
    parameter int RD_LAT    = 1,
    parameter int SHIFT     = 10,
    parameter int WL_W      = 12,
    parameter int WL_MAX    = 1500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_ready,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [63:0]       rd_data,
    input  logic [WL_W-1:0]   wr_water_level,
    output logic              out_en,
    output logic [15:0]       out_data,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun
);
    localparam int HOP   = FRAME_LEN / 2;
    localparam int HOP_W = ADDR_W - 1;

    typedef enum logic [1:0] {IDLE, WAIT_SPACE, READ, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        flush_cnt_q, flush_cnt_d;
    logic              pending_q, pending_d;
    logic              overrun_q, overrun_d;
    logic              first_frame_q, first_frame_d;
    logic              frame_done_q, frame_done_d;
    logic              enter_read;
    logic              space_ok;

    assign space_ok = (wr_water_level <= WL_W'(WL_MAX));

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        flush_cnt_d   = flush_cnt_q;
        first_frame_d = first_frame_q;
        frame_done_d  = 1'b0;
        pending_d     = pending_q;
        overrun_d     = overrun_q;
        enter_read    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_q) state_d = WAIT_SPACE;
            end
            WAIT_SPACE: begin
                if (space_ok) begin
                    state_d    = READ;
                    enter_read = 1'b1;
                end
            end
            READ: begin
                addr_d = addr_q + 1'b1;
                if (addr_q == ADDR_W'(FRAME_LEN - 1)) begin
                    state_d     = FLUSH;
                    flush_cnt_d = '0;
                end
            end
            FLUSH: begin
                if (flush_cnt_q == 2'(RD_LAT)) begin
                    state_d       = IDLE;
                    frame_done_d  = 1'b1;
                    first_frame_d = 1'b0;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A request arriving as the pending one is consumed simply re-arms it.
        if (frame_ready) begin
            if (pending_q && !enter_read) overrun_d = 1'b1;
            pending_d = 1'b1;
        end else if (enter_read) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            flush_cnt_q   <= '0;
            pending_q     <= 1'b0;
            overrun_q     <= 1'b0;
            first_frame_q <= 1'b1;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            flush_cnt_q   <= flush_cnt_d;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            first_frame_q <= first_frame_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign rd_en      = (state_q == READ);
    assign rd_addr    = addr_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

    // Address/valid pipeline tracking each point until its data returns.
    logic              vld_q   [1:RD_LAT];
    logic [ADDR_W-1:0] kaddr_q [1:RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= RD_LAT; i++) vld_q[i] <= 1'b0;
        end else begin
            vld_q[1] <= rd_en;
            for (int i = 2; i <= RD_LAT; i++) vld_q[i] <= vld_q[i-1];
        end
        kaddr_q[1] <= addr_q;
        for (int i = 2; i <= RD_LAT; i++) kaddr_q[i] <= kaddr_q[i-1];
    end

    // Overlap RAM read is launched one cycle early so it lines up with rd_data.
    logic [HOP_W-1:0] ovl_raddr;
    if (RD_LAT == 1) begin : g_raddr_direct
        assign ovl_raddr = addr_q[HOP_W-1:0];
    end else begin : g_raddr_piped
        assign ovl_raddr = kaddr_q[RD_LAT-1][HOP_W-1:0];
    end

    function automatic logic [15:0] sat16(input logic signed [32:0] v);
        if (v > 33'sd32767)       return 16'h7FFF;
        else if (v < -33'sd32768) return 16'h8000;
        else                      return v[15:0];
    endfunction

    logic [ADDR_W-1:0]   k_cur;
    logic                second_half;
    logic                pt_valid;
    logic signed [31:0]  s_val;
    logic [15:0]         ovl_term;
    logic signed [32:0]  s_ext;
    logic signed [32:0]  sum;
    logic                unused_imag;

    assign k_cur       = kaddr_q[RD_LAT];
    assign second_half = k_cur[ADDR_W-1];
    assign pt_valid    = vld_q[RD_LAT];
    assign s_val       = $signed(rd_data[31:0]) >>> SHIFT;
    assign s_ext       = {s_val[31], s_val};
    assign unused_imag = ^rd_data[63:32];

    logic [15:0] ovl_mem [HOP];
    logic [15:0] ovl_rd_q;

    assign ovl_term = first_frame_q ? 16'd0 : ovl_rd_q;
    assign sum      = s_ext + {{17{ovl_term[15]}}, ovl_term};

    always_ff @(posedge clk) begin
        ovl_rd_q <= ovl_mem[ovl_raddr];
        if (pt_valid && second_half) ovl_mem[k_cur[HOP_W-1:0]] <= sat16(s_ext);
    end

    logic        out_en_q;
    logic [15:0] out_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_en_q   <= 1'b0;
            out_data_q <= '0;
        end else begin
            out_en_q <= pt_valid && !second_half;
            if (pt_valid && !second_half) out_data_q <= sat16(sum);
        end
    end

    assign out_en   = out_en_q;
    assign out_data = out_data_q;

endmodule

// File: tb/tb_ifft_ola_reader.sv
// Directed bench for ifft_ola_reader: frames with known real parts, overlap-add,
// saturation, water-level gating, overrun and mid-frame reset.
module tb_ifft_ola_reader;
    localparam int FRAME_LEN = 1024;
    localparam int HOP       = 512;
    localparam int RD_LAT    = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_ready;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data = '0;
    logic [11:0] wr_water_level;
    logic        out_en;
    logic [15:0] out_data;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    ifft_ola_reader #(
        .FRAME_LEN(FRAME_LEN), .ADDR_W(10), .RD_LAT(RD_LAT),
        .SHIFT(10), .WL_W(12), .WL_MAX(1500)
    ) dut (
        .clk(clk), .rst(rst), .frame_ready(frame_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_water_level(wr_water_level),
        .out_en(out_en), .out_data(out_data),
        .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // IFFT result buffer model with one cycle read latency.
    logic [63:0] mem [FRAME_LEN];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    longint exp_arr [HOP];
    int n_tests = 0;
    int n_fail  = 0;

    int st_nout, st_bad, st_t0, st_first_out, st_gaps, st_nrd, st_addr_err;
    int st_done, st_last_rd;
    logic st_busy_done, st_busy_pre;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic fill_mem_const(input logic [31:0] re);
        for (int k = 0; k < FRAME_LEN; k++) mem[k] = {32'hDEAD_BEEF, re};
    endtask

    task automatic fill_exp_const(input longint v);
        for (int k = 0; k < HOP; k++) exp_arr[k] = v;
    endtask

    // Watches one frame until frame_done, optionally pulsing frame_ready at given cycle offsets.
    task automatic monitor_frame(input int pulse_a, input int pulse_b);
        int   exp_addr  = 0;
        int   last_out  = -1;
        logic prev_busy = 1'b0;
        st_nout = 0; st_bad = 0; st_t0 = -1; st_first_out = -1; st_gaps = 0;
        st_nrd = 0; st_addr_err = 0; st_done = -1; st_last_rd = -1;
        st_busy_done = 1'bx; st_busy_pre = 1'bx;
        for (int cyc = 0; cyc < 4000 && st_done < 0; cyc++) begin
            frame_ready = (cyc == pulse_a) || (cyc == pulse_b);
            @(negedge clk);
            if (rd_en === 1'b1) begin
                if (st_t0 < 0) st_t0 = cyc;
                if (rd_addr !== 10'(exp_addr)) st_addr_err++;
                exp_addr++;
                st_nrd++;
                st_last_rd = cyc;
            end
            if (out_en === 1'b1) begin
                if (st_first_out < 0) st_first_out = cyc;
                else if (cyc != last_out + 1) st_gaps++;
                last_out = cyc;
                if (st_nout >= HOP) st_bad++;
                else if ($isunknown(out_data)) st_bad++;
                else if (longint'($signed(out_data)) != exp_arr[st_nout]) st_bad++;
                st_nout++;
            end
            if (frame_done === 1'b1) begin
                st_done      = cyc;
                st_busy_done = busy;
                st_busy_pre  = prev_busy;
            end
            prev_busy = busy;
        end
        frame_ready = 1'b0;
    endtask

    task automatic check_frame(input string tag);
        chk({tag, " samples"},      st_nout, HOP);
        chk({tag, " bad_values"},   st_bad, 0);
        chk({tag, " latency"},      st_first_out - st_t0, RD_LAT + 1);
        chk({tag, " gaps"},         st_gaps, 0);
        chk({tag, " reads"},        st_nrd, FRAME_LEN);
        chk({tag, " addr_seq"},     st_addr_err, 0);
        chk({tag, " done_seen"},    st_done >= 0, 1);
        chk({tag, " done_delay"},   st_done - st_last_rd, RD_LAT + 2);
        chk({tag, " busy_pre"},     st_busy_pre, 1);
        chk({tag, " busy_at_done"}, st_busy_done, 0);
        $display("[TB] frame %s: %0d samples, %0d bad, done at cycle %0d", tag, st_nout, st_bad, st_done);
    endtask

    initial begin
        int cnt_rd;
        int cnt_busy;
        logic found;

        rst = 1'b1; frame_ready = 1'b0; wr_water_level = 12'd0;
        repeat (3) @(negedge clk);
        chk("reset rd_en",      rd_en, 0);
        chk("reset rd_addr",    rd_addr, 0);
        chk("reset out_en",     out_en, 0);
        chk("reset out_data",   out_data, 0);
        chk("reset busy",       busy, 0);
        chk("reset frame_done", frame_done, 0);
        chk("reset overrun",    overrun, 0);
        rst = 1'b0;
        @(negedge clk);

        // Constant 1024 -> 1 per frame; second frame adds stored 1.
        fill_mem_const(32'd1024);
        fill_exp_const(1);      monitor_frame(0, -1); check_frame("A_first");
        fill_exp_const(2);      monitor_frame(0, -1); check_frame("B_ola");

        // Saturation: positive then negative full-scale.
        fill_mem_const(32'h01FF_FC00);
        fill_exp_const(32767);  monitor_frame(0, -1); check_frame("C_pos");
        fill_exp_const(32767);  monitor_frame(0, -1); check_frame("D_possat");
        fill_mem_const(32'hFE00_0000);
        fill_exp_const(-1);     monitor_frame(0, -1); check_frame("E_neg");
        fill_exp_const(-32768); monitor_frame(0, -1); check_frame("F_negsat");
        fill_mem_const(32'h7FFF_FFFF);
        fill_exp_const(32767);  monitor_frame(0, -1); check_frame("G_bigsat");
        fill_mem_const(32'h0000_0000);
        fill_exp_const(32767);  monitor_frame(0, -1); check_frame("H_storedsat");

        // Ramp checks per-index overlap addressing.
        for (int k = 0; k < FRAME_LEN; k++) begin
            int v;
            v = 3 * k - 1000;
            mem[k] = {32'hDEAD_BEEF, 32'(v * 1024)};
        end
        for (int k = 0; k < HOP; k++) exp_arr[k] = 3 * k - 1000;
        monitor_frame(0, -1); check_frame("I_ramp");
        fill_mem_const(32'h0000_0000);
        for (int k = 0; k < HOP; k++) exp_arr[k] = 3 * k + 536;
        monitor_frame(0, -1); check_frame("J_ramp_ovl");
        fill_mem_const(32'hFFFF_FFFF);
        fill_exp_const(-1);     monitor_frame(0, -1); check_frame("K_arith_shift");

        // Water-level gating, boundary, and a request arriving as pending clears.
        fill_mem_const(32'd1024);
        wr_water_level = 12'd2000;
        frame_ready = 1'b1; @(negedge clk); frame_ready = 1'b0;
        cnt_rd = 0; cnt_busy = 0;
        repeat (20) begin
            @(negedge clk);
            if (rd_en === 1'b1) cnt_rd++;
            if (busy === 1'b1) cnt_busy++;
        end
        chk("bp rd_en_while_full", cnt_rd, 0);
        chk("bp busy_while_full", cnt_busy, 20);
        wr_water_level = 12'd1501;
        cnt_rd = 0;
        repeat (5) begin
            @(negedge clk);
            if (rd_en === 1'b1) cnt_rd++;
        end
        chk("bp rd_en_at_1501", cnt_rd, 0);
        wr_water_level = 12'd1500;
        frame_ready = 1'b1; @(negedge clk); frame_ready = 1'b0;
        chk("bp read_start rd_en", rd_en, 1);
        chk("bp read_start rd_addr", rd_addr, 0);
        chk("bp read_start overrun", overrun, 0);
        fill_exp_const(0);
        monitor_frame(-1, -1);
        chk("bp frame samples", st_nout, HOP);
        chk("bp frame bad_values", st_bad, 0);
        chk("bp frame done_seen", st_done >= 0, 1);
        $display("[TB] frame bp: %0d samples, %0d bad", st_nout, st_bad);
        fill_exp_const(2);      monitor_frame(-1, -1); check_frame("bp_repeat");
        chk("bp overrun_after", overrun, 0);
        wr_water_level = 12'd0;

        // Overrun: one extra request during READ is kept, two more lose one.
        monitor_frame(0, 100);  check_frame("O1");
        chk("O1 overrun", overrun, 0);
        monitor_frame(100, 200); check_frame("O2");
        chk("O2 overrun", overrun, 1);
        monitor_frame(-1, -1);  check_frame("O3");
        chk("O3 overrun_sticky", overrun, 1);

        // Reset mid-frame, then the next frame must not add stored overlap.
        frame_ready = 1'b1; @(negedge clk); frame_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (rd_en === 1'b1 && rd_addr === 10'd300) found = 1'b1;
        end
        chk("rst reach_addr300", found, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst rd_en",      rd_en, 0);
        chk("rst rd_addr",    rd_addr, 0);
        chk("rst out_en",     out_en, 0);
        chk("rst out_data",   out_data, 0);
        chk("rst busy",       busy, 0);
        chk("rst frame_done", frame_done, 0);
        chk("rst overrun",    overrun, 0);
        rst = 1'b0;
        @(negedge clk);
        fill_exp_const(1);      monitor_frame(0, -1); check_frame("R_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ifft_ola_reader.md
Name: ifft_ola_reader

Overview:
- Consumer side of the IFFT result buffer in the HPSS datapath.
- After the IFFT signals a finished frame, the block reads the 1024-point frame by address, one point per cycle, and takes the real part.
- It performs 50% overlap-add, with hop = FRAME_LEN/2, against the stored second half of the previous frame.
- It pushes HOP saturated 16-bit samples into the output voice FIFO, gated by that FIFO's write water level.

Parameters:
- FRAME_LEN, 1024, IFFT frame length in points; power of two.
- ADDR_W, 10, log2(FRAME_LEN).
- RD_LAT, 1, cycles from rd_addr/rd_en to valid rd_data; legal values 1..3.
- SHIFT, 10, arithmetic right shift applied to the IFFT real part before overlap-add.
- WL_W, 12, width of the FIFO water-level input.
- WL_MAX, 1500, a frame read may start only while wr_water_level <= WL_MAX.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous reset, active-high.
- frame_ready, input, 1, single-cycle pulse from the IFFT meaning a result frame is complete in its buffer.
- rd_en, output, 1, read strobe to the IFFT result buffer.
- rd_addr, output, ADDR_W, read address into the IFFT result buffer.
- rd_data, input, 64, IFFT point; [31:0] is the signed real part, [63:32] is the imaginary part (ignored).
- wr_water_level, input, WL_W, fill level of the output FIFO.
- out_en, output, 1, FIFO write enable; one sample per asserted cycle.
- out_data, output, 16, signed output sample.
- busy, output, 1, high from leaving IDLE until returning to IDLE.
- frame_done, output, 1, single-cycle pulse after the last output sample of a frame.
- overrun, output, 1, sticky; a frame_ready was lost.

Behaviour:
- Reset values: rd_en=0, rd_addr=0, out_en=0, out_data=0, busy=0, frame_done=0, overrun=0; pending=0, first_frame=1, state=IDLE.
- Reset mid-frame aborts the frame immediately; overlap contents become don't-care because first_frame=1.
- pending flag:
  - Set by frame_ready; cleared when READ is entered.
  - frame_ready while pending=1 sets overrun; the extra frame is dropped.
  - frame_ready in the same cycle pending clears: pending stays 1 for the new frame, no overrun.
- IDLE: if pending, go to WAIT_SPACE.
- WAIT_SPACE: when wr_water_level <= WL_MAX, go to READ and clear pending. This guarantees room for HOP samples.
- READ: rd_en=1 for exactly FRAME_LEN consecutive cycles; rd_addr = 0,1,...,FRAME_LEN-1. After the last address, go to FLUSH.
- FLUSH: wait RD_LAT+1 cycles for the pipeline to drain, then pulse frame_done for one cycle, set first_frame=0, and go to IDLE.
- busy=1 in every state except IDLE.
- Data path, for the point at address k (rd_data valid RD_LAT cycles after its address):
  - s = rd_data[31:0] >>> SHIFT, arithmetic, kept at 32 bits.
  - k < HOP: y = s + ovl[k] (ovl[k] taken as 0 when first_frame=1); sum in 33 bits; saturate to [-32768, 32767]. Register the result: out_data=y, out_en=1, one cycle after the data is valid. Total latency from address to out_en is RD_LAT+1.
  - k >= HOP: ovl[k-HOP] = s saturated to 16 bits; out_en stays 0.
- out_en therefore forms one contiguous burst of exactly HOP cycles per frame, with no gaps. out_data holds its last value while out_en=0.
- ovl is a HOP x 16 storage array with no reset.
  - For a given index, the read of ovl[k] (first half of frame n+1) always happens after the write of ovl[k] (second half of frame n), so no bypass is needed.
- wr_water_level is checked only in WAIT_SPACE; it is not rechecked during READ.

Test Plan:
- Reset then single frame, all rd_data=0x0000_0000_0000_0400 (real 1024), SHIFT=10 → 512 out_en cycles of out_data=1, first at cycle RD_LAT+1 after rd_addr=0; frame_done 1 cycle after FLUSH; busy drops next cycle.
- Two back-to-back frames, real 1024 everywhere → frame 1 outputs 1; frame 2 outputs 2 (1 + stored 1) for all 512 samples.
- Saturation: frame 1 real = 32767<<10, frame 2 same → frame 2 out_data=32767. Repeat with negative values → -32768.
- Backpressure: wr_water_level=2000 when frame_ready pulses → block stays in WAIT_SPACE with rd_en=0; drop level to 1500 → READ starts next cycle.
- Overrun: frame_ready during READ (accepted as pending, second frame processed, overrun=0), then two more pulses during that frame → overrun=1 and stays set until rst.
- rst asserted at rd_addr=300 → all outputs 0 next cycle; next frame behaves as a first frame (no overlap added).
